// File: rtl/pipeline_fork_masked_eager.sv
// Buffered multicast fork: one ready/valid input is replicated to the lanes named in its mask.
// Every output is a register, so output_ready never reaches input_ready combinationally.
module pipeline_fork_masked_eager #(
    parameter  int WORD_WIDTH   = 8,
    parameter  int OUTPUT_COUNT = 4,
    parameter  int STALL_WIDTH  = 8,
    localparam int TOTAL_WIDTH  = WORD_WIDTH * OUTPUT_COUNT
) (
    input  logic                    clock,
    input  logic                    clear_n,
    input  logic                    input_valid,
    output logic                    input_ready,
    input  logic [WORD_WIDTH-1:0]   input_data,
    input  logic [OUTPUT_COUNT-1:0] input_mask,
    output logic [OUTPUT_COUNT-1:0] output_valid,
    input  logic [OUTPUT_COUNT-1:0] output_ready,
    output logic [TOTAL_WIDTH-1:0]  output_data,
    output logic                    busy,
    output logic [STALL_WIDTH-1:0]  stall_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_r;
    logic                    input_ready_r;
    logic [OUTPUT_COUNT-1:0] pending_r;
    logic [WORD_WIDTH-1:0]   buffer_r;
    logic                    busy_r;
    logic [STALL_WIDTH-1:0]  stall_r;

    logic                    accept_s;
    logic                    mask_nonzero_s;
    logic [OUTPUT_COUNT-1:0] done_s;
    logic [OUTPUT_COUNT-1:0] remaining_s;
    logic                    stall_max_s;

    // Handshake decode: lanes completing this cycle and what is still owed.
    always_comb begin
        accept_s       = input_valid & input_ready_r;
        mask_nonzero_s = (input_mask != {OUTPUT_COUNT{1'b0}});
        done_s         = pending_r & output_ready;
        remaining_s    = pending_r & ~done_s;
        stall_max_s    = (stall_r == {STALL_WIDTH{1'b1}});
    end

    // Scheduler state, pending-lane mask, word buffer and stall counter.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_r       <= IDLE;
            input_ready_r <= 1'b0;
            pending_r     <= {OUTPUT_COUNT{1'b0}};
            buffer_r      <= {WORD_WIDTH{1'b0}};
            busy_r        <= 1'b0;
            stall_r       <= {STALL_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    // A zero-mask word is consumed here and simply dropped.
                    if (accept_s && mask_nonzero_s) begin
                        buffer_r      <= input_data;
                        pending_r     <= input_mask;
                        stall_r       <= {STALL_WIDTH{1'b0}};
                        input_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                        state_r       <= SEND;
                    end else begin
                        input_ready_r <= 1'b1;
                        pending_r     <= {OUTPUT_COUNT{1'b0}};
                        busy_r        <= 1'b0;
                        state_r       <= IDLE;
                    end
                end
                SEND: begin
                    pending_r <= remaining_s;
                    if (remaining_s == {OUTPUT_COUNT{1'b0}}) begin
                        input_ready_r <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= IDLE;
                    end else if (!stall_max_s) begin
                        stall_r <= stall_r + {{(STALL_WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        stall_r <= stall_r;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    input_ready_r <= 1'b0;
                    pending_r     <= {OUTPUT_COUNT{1'b0}};
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    assign input_ready  = input_ready_r;
    assign output_valid = pending_r;
    assign output_data  = {OUTPUT_COUNT{buffer_r}};
    assign busy         = busy_r;
    assign stall_count  = stall_r;

endmodule

// File: tb/tb_pipeline_fork_masked_eager.sv
// Self-checking bench for pipeline_fork_masked_eager: directed scenarios plus random traffic
// checked every cycle against a transaction-level model of the multicast scheduler.
module tb_pipeline_fork_masked_eager;

    localparam int WW = 8;
    localparam int OC = 4;
    localparam int SW = 4;

    logic          clock = 1'b0;
    logic          clear_n;
    logic          input_valid;
    logic          input_ready;
    logic [WW-1:0] input_data;
    logic [OC-1:0] input_mask;
    logic [OC-1:0] output_valid;
    logic [OC-1:0] output_ready;
    logic [WW*OC-1:0] output_data;
    logic          busy;
    logic [SW-1:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one outstanding word, the lanes still owed it, and its wait time.
    bit          m_busy;
    bit          m_ready;
    int          m_owed;
    int          m_word;
    int          m_wait;
    int          m_dropped;

    pipeline_fork_masked_eager #(
        .WORD_WIDTH(WW), .OUTPUT_COUNT(OC), .STALL_WIDTH(SW)
    ) dut (
        .clock(clock), .clear_n(clear_n),
        .input_valid(input_valid), .input_ready(input_ready),
        .input_data(input_data), .input_mask(input_mask),
        .output_valid(output_valid), .output_ready(output_ready),
        .output_data(output_data), .busy(busy), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_ready = 1'b0;
        m_owed  = 0;
        m_word  = 0;
        m_wait  = 0;
    endtask

    // One clock of scheduler behaviour, applied to the inputs present at the edge.
    task automatic model_step();
        if (!m_busy) begin
            if (input_valid && m_ready) begin
                if (input_mask != 4'd0) begin
                    m_word  = int'(input_data);
                    m_owed  = int'(input_mask);
                    m_wait  = 0;
                    m_busy  = 1'b1;
                    m_ready = 1'b0;
                end else begin
                    m_dropped++;
                end
            end else begin
                m_ready = 1'b1;
            end
        end else begin
            m_owed = m_owed & ~int'(output_ready);
            if (m_owed == 0) begin
                m_busy  = 1'b0;
                m_ready = 1'b1;
            end else begin
                m_wait = (m_wait + 1 > (1 << SW) - 1) ? (1 << SW) - 1 : m_wait + 1;
            end
        end
    endtask

    task automatic compare_all();
        check("input_ready",  32'(input_ready),  32'(m_ready));
        check("output_valid", 32'(output_valid), 32'(m_busy ? m_owed : 0));
        check("busy",         32'(busy),         32'(m_busy));
        check("stall_count",  32'(stall_count),  32'(m_wait));
        check("output_data",  output_data,       {4{m_word[7:0]}});
    endtask

    task automatic cycle();
        @(posedge clock);
        if (clear_n) model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input logic [3:0] m, input logic [3:0] r);
        input_valid  = v;
        input_data   = d;
        input_mask   = m;
        output_ready = r;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!(m_ready && !m_busy) && guard < 40) begin
            drive(1'b0, 8'h00, 4'h0, 4'hF);
            cycle();
            guard++;
        end
        check("idle_timeout", 32'(guard < 40), 32'd1);
    endtask

    initial begin
        int low_cycles;
        m_dropped = 0;
        model_reset();
        clear_n = 1'b0;
        drive(1'b0, 8'h00, 4'h0, 4'h0);

        // Reset held three cycles while inputs toggle
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
            @(posedge clock);
            #1;
            compare_all();
        end
        drive(1'b0, 8'h00, 4'h0, 4'h0);
        clear_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(input_ready), 32'd0);
        cycle();
        check("ready_after_release", 32'(input_ready), 32'd1);

        // Broadcast
        drive(1'b1, 8'hA5, 4'b1111, 4'b1111);
        cycle();
        check("bcast_valid", 32'(output_valid), 32'h0000000F);
        check("bcast_data",  output_data,       32'hA5A5A5A5);
        drive(1'b0, 8'h00, 4'h0, 4'b1111);
        cycle();
        check("bcast_idle",  32'(input_ready),  32'd1);
        check("bcast_stall", 32'(stall_count),  32'd0);

        // Staggered completion: lane0 @1, lane3 @3, lane1 @5
        drive(1'b1, 8'h5E, 4'b1011, 4'b0000);
        cycle();
        low_cycles = (input_ready == 1'b0) ? 1 : 0;
        check("stag_valid0", 32'(output_valid), 32'h0000000B);
        drive(1'b0, 8'h00, 4'h0, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            output_ready = (k == 1) ? 4'b0001 : (k == 3) ? 4'b1000 : (k == 5) ? 4'b0010 : 4'b0000;
            cycle();
            if (k == 1) check("stag_valid1", 32'(output_valid), 32'h0000000A);
            if (k == 3) check("stag_valid3", 32'(output_valid), 32'h00000002);
            if (k == 4) check("stag_stall4", 32'(stall_count),  32'd4);
            if (input_ready == 1'b0) low_cycles++;
        end
        check("stag_valid5", 32'(output_valid), 32'd0);
        check("stag_low_cycles", 32'(low_cycles), 32'd5);

        // Zero mask words are consumed without leaving IDLE
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'($urandom), 4'b0000, 4'($urandom));
            cycle();
            check("zero_busy", 32'(busy), 32'd0);
        end
        check("zero_dropped", 32'(m_dropped), 32'd3);

        // Stall counter saturation
        drive(1'b1, 8'hC7, 4'b0001, 4'b0000);
        cycle();
        drive(1'b0, 8'h00, 4'h0, 4'b1110);
        for (int i = 0; i < 20; i++) cycle();
        check("sat_stall", 32'(stall_count), 32'd15);
        check("sat_data",  output_data,      32'hC7C7C7C7);
        output_ready = 4'b0001;
        cycle();
        check("sat_done", 32'(output_valid), 32'd0);

        // Reset during SEND, then a fresh word
        drive(1'b1, 8'h99, 4'b0110, 4'b0000);
        cycle();
        drive(1'b0, 8'h00, 4'h0, 4'b0000);
        cycle();
        clear_n = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", 32'(output_valid), 32'd0);
        compare_all();
        cycle();
        clear_n = 1'b1;
        cycle();
        drive(1'b1, 8'h3C, 4'b0100, 4'b0000);
        cycle();
        check("fresh_valid", 32'(output_valid), 32'h00000004);
        check("fresh_data",  output_data,       32'h3C3C3C3C);
        drive(1'b0, 8'h00, 4'h0, 4'b0100);
        cycle();
        wait_idle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom),
                  4'($urandom));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
